rr_onehot_arbiter: RTL and testbench
====================================

Name: rr_onehot_arbiter

Overview:
- Round-robin arbiter that turns N raw request lines into a registered, strictly one-hot (or all-zero) grant vector.
- Sits directly upstream of the one-hot encoder. Its grant vector drives the encoder's input, so the encoder's valid output is always 1 while a grant is held.
- Holds each grant until the owner releases it, drops its request, or exceeds a hold limit.

Parameters:
- N, 8, number of requesters; must be 2 or more.
- MAX_HOLD, 16, maximum consecutive cycles a single grant may be held; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  request lines; req[i]=1 means requester i wants ownership.
- release  input  1  single-cycle pulse from the current owner ending its grant; ignored when no grant is held.
- grant  output  N  registered grant vector; always zero or one-hot.
- grant_valid  output  1  equals the OR of all grant bits; registered alongside grant.
- timeout  output  1  one-cycle pulse, asserted in the first cycle after a grant was forcibly ended by the hold limit.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n).
- While rst_n=0, all outputs are forced to 0 immediately, independent of clk:
  - grant=0, grant_valid=0, timeout=0.
  - State=IDLE, priority pointer ptr=0, hold counter=0.
- State IDLE (grant=0):
  - On a rising edge with req!=0, select the first index k with req[k]=1, searching upward from ptr and wrapping N-1 to 0.
  - Next cycle: grant=one-hot(k), grant_valid=1, ptr=(k+1) mod N, hold counter=0, state=GRANTED.
  - With req=0, stay in IDLE.
  - Latency: req sampled high at edge E gives grant visible after edge E.
- State GRANTED (owner k):
  - At each edge, evaluate the end conditions in this priority order:
    1. release=1.
    2. req[k]=0.
    3. MAX_HOLD!=0 and hold counter==MAX_HOLD-1.
  - If any condition holds: next cycle grant=0, state=IDLE.
  - timeout=1 for that one cycle only when condition 3 alone caused the end.
  - Otherwise: grant unchanged, hold counter increments.
  - Effect: a grant lasts at most MAX_HOLD cycles.
- Idle gap: every grant end is followed by exactly one IDLE cycle with grant=0 before the next grant, even if requests are pending. The downstream encoder therefore sees a zero vector between owners.
- Requests from non-owners during GRANTED are ignored and do not preempt the owner.
- A requester whose grant timed out stays eligible. If it is the only requester, it is re-granted after the one-cycle gap.
- Width rules:
  - ptr is $clog2(N) bits and wraps modulo N, including non-power-of-two N.
  - The hold counter is wide enough for MAX_HOLD-1 and never wraps.
- Invariant: grant is never multi-hot; the bench checks this every cycle.

Test Plan (N=8, MAX_HOLD=4):
1. Reset, then req=8'b1000_0001 → grant=8'h01 one edge later. Pulse release → grant=8'h00 for one cycle, then grant=8'h80, ptr=0.
2. req=8'hFF held, release pulsed each granted cycle → grant sequence 01,00,02,00,04,…,80,00,01. The downstream encoder outputs valid=1 with O=0,1,2,…,7,0 on granted cycles.
3. req=8'h10 held, no release → grant=8'h10 for exactly 4 cycles, then grant=00 with timeout=1 for one cycle, then grant=8'h10 again (ptr wraps from 5 back around to 4).
4. Grant 8'h04 active; req drops to 8'h00 mid-grant → grant=00 next cycle, timeout stays 0; with req=0 the block stays in IDLE.
5. release=1 on the same edge the hold counter reaches 3 → grant=00 next cycle, timeout=0 (release has priority).
6. rst_n asserted low asynchronously while grant=8'h20 → grant=00 and grant_valid=0 immediately without a clock edge. After rst_n returns high with req=8'hFF → first grant=8'h01 (ptr reset to 0).

Source files
------------

// File: rtl/rr_onehot_arbiter.sv
// -----------------------------------------------------------------------------
// rr_onehot_arbiter
//
// Round-robin arbiter producing a registered grant vector that is always
// either all-zero or one-hot. It feeds a one-hot encoder directly, so the
// encoder sees a clean zero vector in the single idle cycle between owners.
//
// A grant is held until the owner pulses its release input, drops its request,
// or has held the grant for MAX_HOLD consecutive cycles. Every grant end is
// followed by exactly one idle cycle before the next grant is issued.
//
// Parameters
//   N         number of requesters (>= 2)
//   MAX_HOLD  maximum consecutive grant cycles; 0 disables the hold limit
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   req[N-1:0]     request lines, req[i]=1 means requester i wants ownership
//   release_pulse  one-cycle pulse from the current owner ending its grant
//                  (ignored while idle); "release" itself is a reserved word
//   grant[N-1:0]   registered grant vector, zero or one-hot
//   grant_valid    registered OR of all grant bits
//   timeout        one-cycle pulse in the first cycle after a grant was ended
//                  by the hold limit
// -----------------------------------------------------------------------------
module rr_onehot_arbiter #(
   parameter int N        = 8,
   parameter int MAX_HOLD = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         release_pulse,
   output logic [N-1:0] grant,
   output logic         grant_valid,
   output logic         timeout
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

   localparam logic [PW-1:0] LAST_IDX  = PW'(N - 1);
   // With the limit disabled the compare below is masked off, so the value
   // chosen here does not matter.
   localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

   typedef enum logic {
      IDLE    = 1'b0,
      GRANTED = 1'b1
   } state_t;

   state_t        state_reg;
   logic [PW-1:0] ptr_reg;
   logic [HW-1:0] hold_reg;

   // -------------------------------------------------------------------------
   // Round-robin pick: first requester at or above ptr, wrapping modulo N.
   // The wrap is done arithmetically so non-power-of-two N never indexes past
   // the last requester.
   // -------------------------------------------------------------------------
   function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= N) begin
         s = s - N;
      end
      return PW'(s);
   endfunction

   logic          pick_found;
   logic [PW-1:0] pick_idx;
   logic [PW-1:0] cand;

   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int i = 0; i < N; i++) begin
         cand = wrap_idx(ptr_reg, i);
         if (!pick_found && req[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   logic [PW-1:0] ptr_next;
   assign ptr_next = (pick_idx == LAST_IDX) ? '0 : pick_idx + PW'(1);

   // -------------------------------------------------------------------------
   // End-of-grant conditions, highest priority first: release, owner dropped
   // its request, hold limit. The owner's request is found by masking req with
   // the one-hot grant, so no separate owner index is stored.
   // -------------------------------------------------------------------------
   logic owner_req;
   logic hold_hit;
   logic end_grant;
   logic end_by_limit;

   assign owner_req    = |(req & grant);
   assign hold_hit     = (MAX_HOLD != 0) && (hold_reg == HOLD_LAST);
   assign end_grant    = release_pulse || !owner_req || hold_hit;
   assign end_by_limit = !release_pulse && owner_req && hold_hit;

   // -------------------------------------------------------------------------
   // Controller with registered outputs.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         ptr_reg     <= '0;
         hold_reg    <= '0;
         grant       <= '0;
         grant_valid <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               timeout <= 1'b0;
               if (pick_found) begin
                  grant       <= N'(1) << pick_idx;
                  grant_valid <= 1'b1;
                  ptr_reg     <= ptr_next;
                  hold_reg    <= '0;
                  state_reg   <= GRANTED;
               end else begin
                  grant       <= '0;
                  grant_valid <= 1'b0;
               end
            end

            GRANTED: begin
               if (end_grant) begin
                  // The mandatory one-cycle gap comes from always passing
                  // through IDLE, even when other requests are pending.
                  grant       <= '0;
                  grant_valid <= 1'b0;
                  timeout     <= end_by_limit;
                  state_reg   <= IDLE;
               end else begin
                  timeout <= 1'b0;
                  // Counter stays put when the limit is disabled so it can
                  // never wrap.
                  if (MAX_HOLD != 0) begin
                     hold_reg <= hold_reg + HW'(1);
                  end
               end
            end

            default: begin
               state_reg   <= IDLE;
               grant       <= '0;
               grant_valid <= 1'b0;
               timeout     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for rr_onehot_arbiter (N=8, MAX_HOLD=4).
// Stimulus drives inputs on the falling edge and pushes the expected grant /
// timeout for the following rising edge into a queue. A separate monitor
// samples 1 time unit after each rising edge, pops and compares, and also
// checks the one-hot / grant_valid invariant on every cycle.
// -----------------------------------------------------------------------------
module tb_rr_onehot_arbiter;

   localparam int N        = 8;
   localparam int MAX_HOLD = 4;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] req;
   logic         release_pulse;
   logic [N-1:0] grant;
   logic         grant_valid;
   logic         timeout;

   rr_onehot_arbiter #(
      .N        (N),
      .MAX_HOLD (MAX_HOLD)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req           (req),
      .release_pulse (release_pulse),
      .grant         (grant),
      .grant_valid   (grant_valid),
      .timeout       (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int           id;
      logic [N-1:0] g;
      logic         to;
   } exp_t;

   exp_t exp_q[$];
   int   tests  = 0;
   int   failed = 0;
   int   step_id = 0;

   // Apply one cycle of stimulus (called at a falling edge) and record the
   // response expected after the next rising edge.
   task automatic step(input logic [N-1:0] r, input logic rel,
                       input logic [N-1:0] eg, input logic eto);
      exp_t e;
      req           = r;
      release_pulse = rel;
      e.id = step_id;
      e.g  = eg;
      e.to = eto;
      exp_q.push_back(e);
      step_id++;
      @(negedge clk);
   endtask

   // Monitor / scoreboard
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         tests++;
         if (($countones(grant) > 1) || (grant_valid !== (|grant))) begin
            failed++;
            $display("FAIL onehot t=%0t grant=%h grant_valid=%b required one-hot with matching valid",
                     $time, grant, grant_valid);
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if ((grant !== e.g) || (timeout !== e.to) || (grant_valid !== (|e.g))) begin
               failed++;
               $display("FAIL step%0d grant=%h gv=%b timeout=%b required grant=%h gv=%b timeout=%b",
                        e.id, grant, grant_valid, timeout, e.g, |e.g, e.to);
            end else begin
               $display("[TB] step%0d req=%h rel=%b grant=%h timeout=%b ok",
                        e.id, req, release_pulse, grant, timeout);
            end
         end
      end
   end

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n         = 1'b0;
      req           = '0;
      release_pulse = 1'b0;
      repeat (3) @(negedge clk);

      tests++;
      if ((grant !== '0) || (grant_valid !== 1'b0) || (timeout !== 1'b0)) begin
         failed++;
         $display("FAIL reset_state grant=%h gv=%b timeout=%b required all zero",
                  grant, grant_valid, timeout);
      end
      rst_n = 1'b1;

      // 1: two requesters, release, gap, wrap to the upper one
      step(8'h81, 1'b0, 8'h01, 1'b0);
      step(8'h81, 1'b1, 8'h00, 1'b0);
      step(8'h81, 1'b0, 8'h80, 1'b0);
      step(8'h00, 1'b1, 8'h00, 1'b0);
      step(8'h00, 1'b0, 8'h00, 1'b0);

      // 2: all requesting, release each grant -> full rotation
      for (int i = 0; i < N; i++) begin
         step(8'hFF, 1'b0, 8'(1 << i), 1'b0);
         step(8'hFF, 1'b1, 8'h00, 1'b0);
      end
      step(8'hFF, 1'b0, 8'h01, 1'b0);
      step(8'h00, 1'b0, 8'h00, 1'b0);
      step(8'h00, 1'b0, 8'h00, 1'b0);

      // 3: single requester hits the hold limit, then is re-granted
      for (int i = 0; i < MAX_HOLD; i++) begin
         step(8'h10, 1'b0, 8'h10, 1'b0);
      end
      step(8'h10, 1'b0, 8'h00, 1'b1);
      step(8'h10, 1'b0, 8'h10, 1'b0);
      step(8'h00, 1'b0, 8'h00, 1'b0);

      // 4: owner drops its request mid-grant, no timeout, stays idle
      step(8'h04, 1'b0, 8'h04, 1'b0);
      step(8'h04, 1'b0, 8'h04, 1'b0);
      step(8'h00, 1'b0, 8'h00, 1'b0);
      step(8'h00, 1'b0, 8'h00, 1'b0);
      step(8'h00, 1'b0, 8'h00, 1'b0);

      // 5: release on the limit edge wins over timeout; non-owner ignored
      step(8'h01, 1'b0, 8'h01, 1'b0);
      step(8'h03, 1'b0, 8'h01, 1'b0);
      step(8'h03, 1'b0, 8'h01, 1'b0);
      step(8'h03, 1'b0, 8'h01, 1'b0);
      step(8'h03, 1'b1, 8'h00, 1'b0);
      step(8'h03, 1'b0, 8'h02, 1'b0);
      step(8'h00, 1'b0, 8'h00, 1'b0);
      step(8'h00, 1'b0, 8'h00, 1'b0);

      // 6: asynchronous reset while a grant is held
      step(8'h20, 1'b0, 8'h20, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if ((grant !== '0) || (grant_valid !== 1'b0) || (timeout !== 1'b0)) begin
         failed++;
         $display("FAIL async_reset grant=%h gv=%b timeout=%b required all zero",
                  grant, grant_valid, timeout);
      end else begin
         $display("[TB] async_reset grant=%h gv=%b cleared without clock edge", grant, grant_valid);
      end
      req = 8'hFF;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      step(8'hFF, 1'b0, 8'h01, 1'b0);
      step(8'hFF, 1'b1, 8'h00, 1'b0);
      step(8'hFF, 1'b0, 8'h02, 1'b0);
      step(8'h00, 1'b0, 8'h00, 1'b0);
      step(8'h00, 1'b0, 8'h00, 1'b0);

      // All expected responses must have been consumed by the monitor
      repeat (2) @(negedge clk);
      tests++;
      if (exp_q.size() != 0) begin
         failed++;
         $display("FAIL scoreboard_drain pending=%0d required 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
